// File: rtl/divide16_seq_if.sv
// Start/done handshake and operand/result bundle
// between the control unit and the sequential divider.
interface divide16_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divide16_seq.sv
// Sequential unsigned restoring divider, one quotient
// bit per clock, with early divide-by-zero exit.
module divide16_seq #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  divide16_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             last;
  logic             zero;

  always_comb begin
    shl    = {r[WIDTH-1:0], q[WIDTH-1]};
    t      = shl - {1'b0, d};
    last   = (cnt == CW'(WIDTH - 1));
    zero   = (bus.divisor == '0);
    r_step = shl;
    q_step = {q[WIDTH-2:0], 1'b0};
    // Restore by simply keeping the shifted value.
    if (!t[WIDTH]) begin
      r_step = t;
      q_step = {q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q               <= '0;
      d               <= '0;
      r               <= '0;
      cnt             <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            q   <= bus.dividend;
            d   <= bus.divisor;
            r   <= '0;
            cnt <= '0;
            // Zero divisor skips iteration entirely.
            if (zero) begin
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          q   <= q_step;
          r   <= r_step;
          cnt <= cnt + CW'(1);
          if (last) begin
            bus.quotient    <= q_step;
            bus.remainder   <= r_step[WIDTH-1:0];
            bus.div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_divide16_seq.sv
// Directed and invariant checks for the
// sequential restoring divider.
module tb_divide16_seq;
  logic clk;
  logic reset;

  int checks;
  int failures;

  divide16_seq_if #(.WIDTH(16)) bus ();

  divide16_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge; returns at
  // the negedge where done is high.
  task automatic wait_done(
    output int   n,
    output logic got,
    output logic all_busy
  );
    n        = 0;
    got      = 1'b0;
    all_busy = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (!bus.busy) all_busy = 1'b0;
      n++;
    end
    if (!got) chk("timeout", 0, 1);
  endtask

  // Called #1 after a posedge with the DUT idle.
  task automatic run_div(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] q,
    output logic [15:0] r,
    output logic        z,
    output int          n,
    output logic        bsy
  );
    logic got;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 16'h5A5A;
    bus.divisor  = 16'h0000;
    wait_done(n, got, bsy);
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    @(posedge clk);
    #1;
    chk("done_1cyc", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  logic [15:0] q;
  logic [15:0] r;
  logic        z;
  int          n;
  logic        bsy;
  logic        got;
  int          dcount;

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_z", bus.div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_div(16'd100, 16'd7, q, r, z, n, bsy);
    chk("d100_7_q", q, 14);
    chk("d100_7_r", r, 2);
    chk("d100_7_z", z, 0);
    chk("d100_7_lat", n, 16);
    chk("d100_7_busy", bsy, 1);

    run_div(16'hFFFF, 16'h0001, q, r, z, n, bsy);
    chk("ffff_1_q", q, 16'hFFFF);
    chk("ffff_1_r", r, 0);
    run_div(16'h0003, 16'h000A, q, r, z, n, bsy);
    chk("3_10_q", q, 0);
    chk("3_10_r", r, 3);
    chk("3_10_lat", n, 16);

    run_div(16'd5, 16'd0, q, r, z, n, bsy);
    chk("dbz_q", q, 16'hFFFF);
    chk("dbz_r", r, 5);
    chk("dbz_z", z, 1);
    chk("dbz_lat", n, 0);
    run_div(16'd9, 16'd3, q, r, z, n, bsy);
    chk("9_3_q", q, 3);
    chk("9_3_r", r, 0);
    chk("9_3_z", z, 0);

    run_div(16'd0, 16'd5, q, r, z, n, bsy);
    chk("0_5_q", q, 0);
    chk("0_5_r", r, 0);
    chk("0_5_lat", n, 16);

    // start held high; new operands must wait for IDLE
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd9;
    @(posedge clk);
    #1;
    bus.dividend = 16'd50;
    bus.divisor  = 16'd5;
    wait_done(n, got, bsy);
    chk("hold_q1", bus.quotient, 111);
    chk("hold_r1", bus.remainder, 1);
    chk("hold_lat1", n, 16);
    @(posedge clk);
    #1;
    chk("hold_idle", bus.busy, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("hold_acc", bus.busy, 1);
    wait_done(n, got, bsy);
    chk("hold_q2", bus.quotient, 10);
    chk("hold_r2", bus.remainder, 0);
    chk("hold_lat2", n, 16);
    @(posedge clk);
    #1;

    // async reset in the middle of an operation
    bus.start    = 1'b1;
    bus.dividend = 16'hBEEF;
    bus.divisor  = 16'h0013;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_done", bus.done, 0);
    chk("ar_q", bus.quotient, 0);
    chk("ar_r", bus.remainder, 0);
    chk("ar_z", bus.div_by_zero, 0);
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    dcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk("ar_nodone", dcount, 0);
    @(posedge clk);
    #1;
    run_div(16'hBEEF, 16'h0013, q, r, z, n, bsy);
    chk("beef_q", q, 16'h0A0C);
    chk("beef_r", r, 16'h000B);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 3 == 0) b = 16'($urandom_range(1, 255));
      if (b == 0) b = 16'd1;
      run_div(a, b, q, r, z, n, bsy);
      chk("rnd_inv", 32'(q) * 32'(b) + 32'(r), 32'(a));
      chk("rnd_rlt", 32'(r < b), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
